// File: rtl/div_arbiter.sv
// div_arbiter: two requesters share one unsigned divider through a round-robin
// arbiter. A granted request is latched into operand registers, held stable for
// LATENCY cycles and then the quotient is captured and announced with valid.
module div_arbiter #(
  parameter int DATAWIDTH = 64,
  parameter int LATENCY   = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 req0,
  input  logic [DATAWIDTH-1:0] a0,
  input  logic [DATAWIDTH-1:0] b0,
  input  logic                 req1,
  input  logic [DATAWIDTH-1:0] a1,
  input  logic [DATAWIDTH-1:0] b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 busy,
  output logic                 valid,
  output logic [DATAWIDTH-1:0] d,
  output logic                 id,
  output logic                 divz
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t               state;
  logic                 ptr;
  logic [3:0]           cnt;
  logic [DATAWIDTH-1:0] opA;
  logic [DATAWIDTH-1:0] opB;
  logic                 owner;
  logic                 zero;
  logic [DATAWIDTH-1:0] quo;

  // Shared divider works only on the latched operands; a zero divisor yields all ones.
  assign zero = (opB == '0);
  assign quo  = zero ? '1 : (opA / opB);

  // Grant decision: only in IDLE and never under reset; a lone requester always wins,
  // otherwise the pointer breaks the tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !Rst) begin
      if (req0 && (!req1 || !ptr)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Control FSM, operand latch, latency counter and registered result outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
      cnt   <= 4'd0;
      opA   <= '0;
      opB   <= '0;
      owner <= 1'b0;
      busy  <= 1'b0;
      valid <= 1'b0;
      d     <= '0;
      id    <= 1'b0;
      divz  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            opA   <= gnt0 ? a0 : a1;
            opB   <= gnt0 ? b0 : b1;
            owner <= gnt1;
            ptr   <= gnt0;
            cnt   <= 4'(LATENCY);
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            d     <= quo;
            divz  <= zero;
            id    <= owner;
            valid <= 1'b1;
            cnt   <= 4'd0;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: drives directed and random divide requests from both requesters.
// A cycle model predicts grants, busy and result timing; results go into a queue
// that an independent monitor drains whenever the DUT raises valid.
module tb_div_arbiter;

  localparam int DW  = 64;
  localparam int LAT = 2;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          req0, req1;
  logic [DW-1:0] a0, b0, a1, b1;
  logic          gnt0, gnt1, busy, valid, id, divz;
  logic [DW-1:0] d;

  div_arbiter #(.DATAWIDTH(DW), .LATENCY(LAT)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .valid(valid),
    .d(d), .id(id), .divz(divz)
  );

  // Free-running clock
  always #5 Clk = ~Clk;

  typedef struct {
    logic          id;
    logic [DW-1:0] q;
    logic          dz;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Cycle index, counted in rising edges
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one operation occupies the divider for LAT+2 cycles counted from
  // its grant; the tie-break favours whoever did not win last time.
  int   freeCnt = 0;
  logic lastWin = 1'b1;
  bit   armed   = 1'b0;
  always @(negedge Clk) begin
    logic eg0, eg1;
    exp_t e;
    #1;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (armed) checkOutput("busy", DW'(busy), DW'(freeCnt > 0));
    if (Rst) begin
      freeCnt = 0;
      lastWin = 1'b1;
      sb.delete();
      armed = 1'b1;
    end else if (freeCnt == 0) begin
      if (req0 && req1) begin
        eg0 = lastWin;
        eg1 = !lastWin;
      end else begin
        eg0 = req0;
        eg1 = req1;
      end
      if (eg0 || eg1) begin
        e.id  = eg1;
        e.q   = eg0 ? ((b0 == 0) ? {DW{1'b1}} : a0 / b0) : ((b1 == 0) ? {DW{1'b1}} : a1 / b1);
        e.dz  = eg0 ? (b0 == 0) : (b1 == 0);
        e.due = cyc + LAT + 1;
        sb.push_back(e);
        lastWin = eg1;
        freeCnt = LAT + 1;
      end
    end else begin
      freeCnt--;
    end
    if (armed) begin
      checkOutput("gnt0", DW'(gnt0), DW'(eg0));
      checkOutput("gnt1", DW'(gnt1), DW'(eg1));
    end
  end

  // Monitor: pops the scoreboard on each due result and checks held values otherwise.
  logic [DW-1:0] holdD  = '0;
  logic          holdId = 1'b0;
  logic          holdDz = 1'b0;
  bit            monArmed = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    if (monArmed) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checkOutput("valid", DW'(valid), DW'(1));
        checkOutput("d", d, e.q);
        checkOutput("id", DW'(id), DW'(e.id));
        checkOutput("divz", DW'(divz), DW'(e.dz));
        holdD  = e.q;
        holdId = e.id;
        holdDz = e.dz;
      end else begin
        checkOutput("idle_valid", DW'(valid), DW'(0));
        checkOutput("hold_d", d, holdD);
        checkOutput("hold_id", DW'(id), DW'(holdId));
        checkOutput("hold_divz", DW'(divz), DW'(holdDz));
      end
    end
    if (Rst) begin
      holdD    = '0;
      holdId   = 1'b0;
      holdDz   = 1'b0;
      monArmed = 1'b1;
    end
  end

  // Presents requests, keeps each high until its grant, then scrambles the operands
  // so a late operand change would corrupt the result if it leaked into the divider.
  task automatic applyStimulus(input bit r0, input logic [DW-1:0] x0, input logic [DW-1:0] y0,
                               input bit r1, input logic [DW-1:0] x1, input logic [DW-1:0] y1);
    bit p0, p1;
    int k;
    req0 = r0; a0 = x0; b0 = y0;
    req1 = r1; a1 = x1; b1 = y1;
    p0 = r0;
    p1 = r1;
    k  = 0;
    while ((p0 || p1) && k < 60) begin
      @(negedge Clk);
      #2;
      if (gnt0) p0 = 1'b0;
      if (gnt1) p1 = 1'b0;
      @(posedge Clk);
      #1;
      if (!p0 && req0) begin req0 = 1'b0; a0 = 64'd9; b0 = 64'd3; end
      if (!p1 && req1) begin req1 = 1'b0; a1 = 64'd9; b1 = 64'd3; end
      k++;
    end
    if (p0 || p1) begin
      total++;
      bad++;
      $display("[TB] FAIL grant_timeout: got no grant expected grant within 60 cycles");
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  function automatic logic [DW-1:0] randDivisor();
    int sel;
    sel = $urandom_range(0, 4);
    if (sel == 0) return '0;
    if (sel <= 2) return DW'($urandom_range(1, 20));
    return {$urandom, $urandom};
  endfunction

  initial begin
    bit            p0, p1;
    logic [DW-1:0] big;
    Rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    idleCycles(3);
    Rst = 1'b0;
    idleCycles(2);

    // Single requester, basic quotient
    applyStimulus(1, 64'd100, 64'd7, 0, '0, '0);
    idleCycles(LAT + 3);
    // Divide by zero from requester 1
    applyStimulus(0, '0, '0, 1, 64'd123, 64'd0);
    idleCycles(LAT + 3);
    // Operands change during BUSY
    applyStimulus(1, 64'd1000, 64'd10, 0, '0, '0);
    idleCycles(LAT + 3);
    // Quotient zero and maximal dividend
    applyStimulus(1, 64'd5, 64'd9, 0, '0, '0);
    idleCycles(LAT + 3);
    big = '1;
    applyStimulus(1, big, 64'd1, 0, '0, '0);
    idleCycles(LAT + 3);

    // Contention straight after reset, then alternating winners
    Rst = 1'b1;
    idleCycles(1);
    Rst = 1'b0;
    applyStimulus(1, 64'd50, 64'd5, 1, 64'd81, 64'd9);
    applyStimulus(1, 64'd50, 64'd5, 1, 64'd81, 64'd9);
    applyStimulus(1, 64'd60, 64'd4, 1, 64'd77, 64'd11);
    idleCycles(LAT + 3);

    // Reset in cycle 1 of an operation aborts it; req1 granted right after
    req0 = 1'b1; a0 = 64'd400; b0 = 64'd8;
    @(negedge Clk);
    @(posedge Clk);
    #1;
    req0 = 1'b0;
    Rst  = 1'b1;
    idleCycles(1);
    Rst = 1'b0;
    applyStimulus(0, '0, '0, 1, 64'd77, 64'd7);
    idleCycles(LAT + 3);

    // Random traffic from both requesters
    p0 = 1'b0;
    p1 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; req0 = 1'b1; a0 = {$urandom, $urandom} >> $urandom_range(0, 60); b0 = randDivisor();
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; req1 = 1'b1; a1 = {$urandom, $urandom} >> $urandom_range(0, 60); b1 = randDivisor();
      end
      @(negedge Clk);
      #2;
      if (gnt0) p0 = 1'b0;
      if (gnt1) p1 = 1'b0;
      @(posedge Clk);
      #1;
      if (!p0) begin req0 = 1'b0; a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom}; end
      if (!p1) begin req1 = 1'b0; a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    idleCycles(3 * (LAT + 3));

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d outstanding results expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: DATAWIDTH, default 64, operand and result width in bits.
REQ-002 Parameter: LATENCY, default 2, cycles the divide operands are held stable before the result is sampled; legal range 1..15.
REQ-003 Clk  input  1  rising-edge clock; the block's only clock.
REQ-004 Rst  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-005 req0  input  1  requester 0 asks for a divide; held high until gnt0 is seen.
REQ-006 a0  input  DATAWIDTH  requester 0 dividend, unsigned.
REQ-007 b0  input  DATAWIDTH  requester 0 divisor, unsigned.
REQ-008 req1  input  1  requester 1 asks for a divide.
REQ-009 a1  input  DATAWIDTH  requester 1 dividend, unsigned.
REQ-010 b1  input  DATAWIDTH  requester 1 divisor, unsigned.
REQ-011 gnt0  output  1  combinational; high in the cycle requester 0 is accepted.
REQ-012 gnt1  output  1  combinational; high in the cycle requester 1 is accepted.
REQ-013 busy  output  1  registered; high in every state except IDLE.
REQ-014 valid  output  1  registered; one-cycle pulse marking a result on d, id and divz.
REQ-015 d  output  DATAWIDTH  registered quotient.
REQ-016 id  output  1  registered; index of the requester that owns the current result.
REQ-017 divz  output  1  registered; high with valid when the divisor was zero.

Function
REQ-018 The block SHALL own one shared unsigned divider, a/b truncating, fed only from internal operand registers opA and opB.
REQ-019 FSM states SHALL be IDLE, BUSY and DONE; Rst forces IDLE.
REQ-020 IDLE: when req0 or req1 is high, the block SHALL accept exactly one requester in that cycle, load opA/opB and the owner from it, and move to BUSY.
REQ-021 Arbitration SHALL be round-robin: a priority pointer selects which requester wins when both are high, and after each grant it points to the other requester.
REQ-022 A lone requester SHALL be granted regardless of the pointer.
REQ-023 gntX SHALL be high only in IDLE, only for the winner, and for exactly one cycle per accepted operation.
REQ-024 gntX SHALL never be high in BUSY or DONE; requests arriving then SHALL wait, not be lost, and not be queued beyond the live req level.
REQ-025 BUSY: a down-counter SHALL load LATENCY on entry and decrement once per cycle; at terminal count the divider output SHALL be captured into d and the FSM SHALL move to DONE.
REQ-026 Timing: acceptance is cycle 0, BUSY covers cycles 1..LATENCY, and valid SHALL be high in cycle LATENCY+1 only.
REQ-027 DONE SHALL last one cycle and return to IDLE; a new grant is possible in the cycle after DONE.
REQ-028 Back-to-back throughput SHALL be one operation per LATENCY+2 cycles.
REQ-029 Divide by zero (opB==0): d SHALL be all ones, divz SHALL be 1, and the FSM flow SHALL be unchanged.
REQ-030 When opB!=0, divz SHALL be 0.
REQ-031 d, id and divz SHALL hold their values after valid falls, until the next capture.
REQ-032 opA and opB SHALL stay stable for the whole of BUSY even if a0/b0/a1/b1 change.

Reset
REQ-033 On Rst the block SHALL clear the state to IDLE, the pointer to requester 0, the counter to 0, busy, valid, d, id and divz all to 0, and opA/opB to 0.
REQ-034 Rst asserted mid-operation SHALL abort it: no valid pulse for the aborted operation, and gnt0/gnt1 SHALL be low while Rst is high.
REQ-035 After Rst deasserts, the first grant SHALL be possible in the next cycle.

Verification
REQ-036 LATENCY=2, DATAWIDTH=64, req0 only, a0=100, b0=7 -> gnt0 pulses in cycle 0, busy high cycles 1-3, valid in cycle 3 with d=14, id=0, divz=0.
REQ-037 req0 and req1 both held high after reset, a0=50/b0=5, a1=81/b1=9 -> first result id=0 d=10, second result id=1 d=9, grants 4 cycles apart, and the pattern then alternates.
REQ-038 req1 only, a1=123, b1=0 -> valid with d=0xFFFF_FFFF_FFFF_FFFF, divz=1, id=1.
REQ-039 req0 with a0=1000/b0=10, a0/b0 changed to 9/3 during BUSY -> d=100.
REQ-040 Rst pulsed in cycle 1 of an operation -> no valid pulse, all outputs 0, and a fresh req1 is granted in the cycle after Rst falls.
REQ-041 a0=5, b0=9 -> d=0; a0=0xFFFF_FFFF_FFFF_FFFF, b0=1 -> d=0xFFFF_FFFF_FFFF_FFFF.
